// File: rtl/chunked_adder_pkg.sv
// Shared types and default sizing for the chunked multi-cycle adder.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/chunked_adder_chunk_add.sv
// Combinational CHUNK-wide adder slice used once per cycle by chunked_adder.
module chunk_add
    import chunked_adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder producing CHUNK sum bits per cycle with a valid/ready handshake.
// Optional signed-overflow output enabled by defining CHUNKED_ADDER_OVF_EN.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid,
`ifdef CHUNKED_ADDER_OVF_EN
    output logic             ovf,
`endif
    input  logic             out_ready
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_out_valid;
    logic [IDX_W-1:0]   r_idx;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_s;
    logic               w_co;
    logic               w_last;

    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];
    assign w_last    = (r_idx == IDX_W'(NCHUNK - 1));

    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a  (w_a_chunk),
        .b  (w_b_chunk),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

`ifdef CHUNKED_ADDER_OVF_EN
    logic r_ovf;
    logic w_cin_msb;

    // On the last chunk the operand MSBs and the sum MSB recover the carry into the MSB.
    assign w_cin_msb = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s[CHUNK-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == ADD) && w_last) begin
            r_ovf <= w_cin_msb ^ w_co;
        end
    end

    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_sum[r_idx*CHUNK +: CHUNK] <= w_s;
                    r_carry                     <= w_co;
                    if (w_last) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Masked by rst so the block never advertises readiness while held in reset.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign sum       = r_sum;
    assign carry     = r_carry;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: 16/4, 8/1 and 8/8 instances against an arithmetic model.
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] A, B;
    logic        cin;
    logic        iv;
    logic        ordy;
    int          sel;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    logic        iv0, iv1, iv2;
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        c0, c1, c2;
    logic [15:0] s0;
    logic [7:0]  s1, s2;

    assign iv0 = iv && (sel == 0);
    assign iv1 = iv && (sel == 1);
    assign iv2 = iv && (sel == 2);

`ifdef CHUNKED_ADDER_OVF_EN
    logic f0, f1, f2;
`endif

    chunked_adder #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk(clk), .rst(rst), .A(A), .B(B), .cin(cin), .in_valid(iv0), .in_ready(ir0),
        .sum(s0), .carry(c0), .out_valid(ov0),
`ifdef CHUNKED_ADDER_OVF_EN
        .ovf(f0),
`endif
        .out_ready(ordy)
    );

    chunked_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk(clk), .rst(rst), .A(A[7:0]), .B(B[7:0]), .cin(cin), .in_valid(iv1), .in_ready(ir1),
        .sum(s1), .carry(c1), .out_valid(ov1),
`ifdef CHUNKED_ADDER_OVF_EN
        .ovf(f1),
`endif
        .out_ready(ordy)
    );

    chunked_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst(rst), .A(A[7:0]), .B(B[7:0]), .cin(cin), .in_valid(iv2), .in_ready(ir2),
        .sum(s2), .carry(c2), .out_valid(ov2),
`ifdef CHUNKED_ADDER_OVF_EN
        .ovf(f2),
`endif
        .out_ready(ordy)
    );

    logic [15:0] o_sum;
    logic        o_carry, o_ov, o_ir, o_ovf;

    always_comb begin
        o_sum   = s0;
        o_carry = c0;
        o_ov    = ov0;
        o_ir    = ir0;
        o_ovf   = 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
        o_ovf   = f0;
`endif
        if (sel == 1) begin
            o_sum   = {8'h00, s1};
            o_carry = c1;
            o_ov    = ov1;
            o_ir    = ir1;
`ifdef CHUNKED_ADDER_OVF_EN
            o_ovf   = f1;
`endif
        end else if (sel == 2) begin
            o_sum   = {8'h00, s2};
            o_carry = c2;
            o_ov    = ov2;
            o_ir    = ir2;
`ifdef CHUNKED_ADDER_OVF_EN
            o_ovf   = f2;
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, req);
        end
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input int hold, input string tag);
        int          w, nch, lat, sa, sb, ss;
        logic [15:0] mask, esum;
        logic [16:0] full;
        logic        ecar, eovf;
        w    = (sel == 0) ? 16 : 8;
        nch  = (sel == 0) ? 4 : ((sel == 1) ? 8 : 1);
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        a    = a & mask;
        b    = b & mask;
        full = {1'b0, a} + {1'b0, b} + {16'h0, c};
        esum = full[15:0] & mask;
        ecar = (w == 16) ? full[16] : full[8];
        sa   = a[w-1] ? (int'(a) - (1 << w)) : int'(a);
        sb   = b[w-1] ? (int'(b) - (1 << w)) : int'(b);
        ss   = sa + sb + int'(c);
        eovf = (ss > ((1 << (w - 1)) - 1)) || (ss < -(1 << (w - 1)));

        chk({tag, "_in_ready_idle"}, 32'(o_ir), 32'd1);
        A = a; B = b; cin = c; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        A = 16'($urandom); B = 16'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!o_ov && lat < 40) begin
            chk({tag, "_in_ready_busy"}, 32'(o_ir), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(nch));
        chk({tag, "_sum"}, 32'(o_sum), 32'(esum));
        chk({tag, "_carry"}, 32'(o_carry), 32'(ecar));
`ifdef CHUNKED_ADDER_OVF_EN
        chk({tag, "_ovf"}, 32'(o_ovf), 32'(eovf));
`endif
        for (int k = 0; k < hold; k++) begin
            iv = 1'b1;
            A = 16'($urandom); B = 16'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(o_ov), 32'd1);
            chk({tag, "_hold_sum"}, 32'(o_sum), 32'(esum));
            chk({tag, "_hold_carry"}, 32'(o_carry), 32'(ecar));
            chk({tag, "_hold_in_ready"}, 32'(o_ir), 32'd0);
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        iv   = 1'b0;
        chk({tag, "_drain_valid"}, 32'(o_ov), 32'd0);
        chk({tag, "_drain_in_ready"}, 32'(o_ir), 32'd1);
    endtask

    initial begin
        int seen;
        rst = 1'b1; iv = 1'b0; ordy = 1'b0; sel = 0;
        A = '0; B = '0; cin = 1'b0;
        #2;
        chk("reset_in_ready", 32'(o_ir), 32'd0);
        chk("reset_out_valid", 32'(o_ov), 32'd0);
        chk("reset_sum", 32'(o_sum), 32'd0);
        chk("reset_carry", 32'(o_carry), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("release_in_ready", 32'(o_ir), 32'd1);

        do_op(16'h1234, 16'h1111, 1'b0, 0, "basic");
        do_op(16'hFFFF, 16'h0001, 1'b0, 5, "ripple_hold");

        // Reset pulse during the second ADD cycle must abandon the operation.
        A = 16'hABCD; B = 16'h1357; cin = 1'b1; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(o_ir), 32'd0);
        chk("midrst_out_valid", 32'(o_ov), 32'd0);
        chk("midrst_sum", 32'(o_sum), 32'd0);
        chk("midrst_carry", 32'(o_carry), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", 32'(o_ir), 32'd1);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (o_ov) seen++;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        do_op(16'd3, 16'd4, 1'b0, 0, "after_rst");

        sel = 1;
        do_op(16'h0080, 16'h0080, 1'b1, 1, "serial_w8");
        sel = 2;
        do_op(16'h0080, 16'h0080, 1'b1, 1, "single_w8");

        sel = 0;
        do_op(16'h7FFF, 16'h0001, 1'b0, 0, "sgn_ovf");
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, "unsgn_wrap");

        for (int i = 0; i < 9; i++) begin
            sel = i % 3;
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL provide parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, with 1 <= CHUNK <= WIDTH.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port A  input  WIDTH  addend A, sampled on accept.
REQ-006 SHALL provide port B  input  WIDTH  addend B, sampled on accept.
REQ-007 SHALL provide port cin  input  1  carry-in, sampled on accept.
REQ-008 SHALL provide port in_valid  input  1  operands valid.
REQ-009 SHALL provide port in_ready  output  1  block can accept operands.
REQ-010 SHALL provide port sum  output  WIDTH  result A+B+cin modulo 2^WIDTH.
REQ-011 SHALL provide port carry  output  1  carry-out of the MSB.
REQ-012 SHALL provide port out_valid  output  1  sum/carry valid.
REQ-013 SHALL provide port out_ready  input  1  consumer takes result.

Function
REQ-014 SHALL implement FSM states IDLE, ADD, DONE; NCHUNK = WIDTH/CHUNK.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-016 On accept: latch A, B; carry register <= cin; chunk index <= 0; state -> ADD.
REQ-017 Each ADD cycle SHALL add chunk idx of A, B plus carry register, write result into sum bits [idx*CHUNK +: CHUNK], update carry register, increment idx.
REQ-018 On the ADD cycle with idx == NCHUNK-1, state SHALL go to DONE; out_valid is therefore high exactly NCHUNK cycles after the accept edge.
REQ-019 In DONE, out_valid = 1; sum and carry SHALL hold stable until out_ready = 1.
REQ-020 DONE with out_ready = 1 SHALL return to IDLE; no accept in that same cycle (in_ready is 0 in DONE).
REQ-021 in_valid while busy SHALL be ignored; A, B, cin changes after accept SHALL NOT affect the result.
REQ-022 CHUNK == WIDTH SHALL give a 1-cycle ADD phase; CHUNK == 1 SHALL give a bit-serial, WIDTH-cycle phase.
REQ-023 out_valid SHALL never be 1 in IDLE or ADD.

Reset
REQ-024 rst = 1 SHALL immediately force state IDLE, sum = 0, carry = 0, out_valid = 0, idx = 0, and the latched operands to 0.
REQ-025 in_ready SHALL be 0 while rst = 1 and 1 in the first cycle after release.
REQ-026 Reset asserted mid-ADD or in DONE SHALL discard the operation; no out_valid SHALL follow.

Configuration
REQ-027 Macro CHUNKED_ADDER_OVF_EN defined: extra port ovf  output  1  two's-complement signed overflow of A+B+cin, valid with out_valid, computed as the carry into the MSB XOR carry out; reset value 0.
REQ-028 Macro undefined: no ovf port and no overflow logic; all other behaviour SHALL be identical.

Structure
REQ-029 Package chunked_adder_pkg SHALL hold the FSM state typedef (IDLE, ADD, DONE) and the default WIDTH and CHUNK constants.
REQ-030 Sub-module chunk_add (combinational, CHUNK-wide a+b+ci -> s, co) SHALL implement the per-cycle adder, instantiated once.

Verification
REQ-031 WIDTH=16, CHUNK=4: A=0x1234, B=0x1111, cin=0 -> sum=0x2345, carry=0, out_valid 4 cycles after accept.
REQ-032 A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, carry=1 (carry ripples across all 4 chunks).
REQ-033 out_ready held 0 for 5 cycles in DONE -> sum/carry/out_valid stable, in_ready=0, new in_valid ignored.
REQ-034 rst pulsed during the 2nd ADD cycle -> out_valid stays 0, sum=0, in_ready=1 after release; next op A=3, B=4 -> sum=7.
REQ-035 WIDTH=8, CHUNK=1, A=0x80, B=0x80, cin=1 -> sum=0x01, carry=1 after 8 cycles; CHUNK=8 -> same result after 1 cycle.
REQ-036 With CHUNKED_ADDER_OVF_EN, WIDTH=16: 0x7FFF+0x0001 -> ovf=1; 0xFFFF+0x0001 -> ovf=0, carry=1.
